// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the 8N1 UART receive/transmit pair.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_CLKS_PER_BIT_9600 = 1250;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous pin, both flops reset high (idle level).
module uart_sync2 (
    input  logic hwclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge hwclk) begin
        if (!rst_n) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with mid-bit sampling, stop-bit check and one-cycle strobes.
// Define UART_RX_MAJORITY_EN to vote 2-of-3 over the last three synchronized samples.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_9600
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [UART_DATA_BITS-1:0] shreg, shreg_n;
    logic [7:0] byte_n;
    logic valid_n, err_n, rx_s, sample, at_half, at_full;

    uart_sync2 u_sync (
        .hwclk(hwclk),
        .rst_n(rst_n),
        .d(rx_in),
        .q(rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge hwclk) begin
        if (!rst_n) hist <= 2'b11;
        else hist <= {hist[0], rx_s};
    end
    assign sample = maj3(rx_s, hist[0], hist[1]);
`else
    assign sample = rx_s;
`endif

    assign at_half = cnt == HALF_LAST;
    assign at_full = cnt == FULL_LAST;
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        bit_n = bit_cnt;
        shreg_n = shreg;
        byte_n = rx_byte;
        valid_n = 1'b0;
        err_n = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n = '0;
            bit_n = '0;
            shreg_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = START;
                        bit_n = '0;
                    end
                end
                START: begin
                    cnt_n = at_half ? '0 : cnt + CW'(1);
                    if (at_half) state_n = sample ? IDLE : DATA;
                end
                DATA: begin
                    cnt_n = at_full ? '0 : cnt + CW'(1);
                    if (at_full) begin
                        shreg_n = {sample, shreg[UART_DATA_BITS-1:1]};
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) state_n = STOP;
                    end
                end
                STOP: begin
                    cnt_n = at_full ? '0 : cnt + CW'(1);
                    if (at_full) begin
                        state_n = sample ? IDLE : BREAK;
                        byte_n = sample ? shreg : rx_byte;
                        valid_n = sample;
                        err_n = !sample;
                    end
                end
                BREAK: if (rx_s) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            rx_byte <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_cnt <= bit_n;
            shreg <= shreg_n;
            rx_byte <= byte_n;
            rx_valid <= valid_n;
            frame_err <= err_n;
        end
    end
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: randomized self-checking bench; a fast instance covers most scenarios,
// a 9600-baud instance covers the exact-timing and glitch cases.
module tb_uart_rx_8n1;
    localparam int C = 20;
    localparam int H = C / 2;
    localparam int CS = 1250;
    localparam int HS = CS / 2;

    logic hwclk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic en_s = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic [7:0] rx_byte, rx_byte_s;
    logic rx_valid, rx_valid_s, frame_err, frame_err_s, busy, busy_s;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] last_byte = 8'h00;

    typedef struct {
        logic [7:0] b;
        int t;
    } ev_t;
    ev_t vq[$];
    ev_t vq_s[$];
    int eq[$];
    int eq_s[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(C)) dut (
        .hwclk(hwclk), .rst_n(rst_n), .en(en), .rx_in(rx_a),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(CS)) dut_s (
        .hwclk(hwclk), .rst_n(rst_n), .en(en_s), .rx_in(rx_b),
        .rx_byte(rx_byte_s), .rx_valid(rx_valid_s), .frame_err(frame_err_s), .busy(busy_s)
    );

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    initial forever begin
        @(posedge hwclk);
        #1;
        if (rx_valid) vq.push_back('{b: rx_byte, t: cyc});
        if (frame_err) eq.push_back(cyc);
        if (rx_valid_s) vq_s.push_back('{b: rx_byte_s, t: cyc});
        if (frame_err_s) eq_s.push_back(cyc);
        if (rx_valid || frame_err) begin
            checks++;
            if (rx_valid && frame_err) begin
                failures++;
                $display("FAIL strobe_exclusive: both strobes high at cycle %0d, required at most one", cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    // Drive one frame bit-by-bit; g is a cycle offset whose line value is inverted (-1: none).
    task automatic send(input logic [7:0] d, input int nstop, input int g, input bit slow, output int t0);
        int c;
        c = slow ? CS : C;
        t0 = cyc + 3;
        for (int k = 0; k < (9 + nstop) * c; k++) begin
            int j;
            logic v;
            j = k / c;
            v = (j == 0) ? 1'b0 : (j <= 8) ? d[j-1] : 1'b1;
            v = v ^ (k == g);
            if (slow) rx_b = v;
            else rx_a = v;
            tick();
        end
        if (slow) rx_b = 1'b1;
        else rx_a = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({rx_byte, rx_valid, frame_err, busy} !== 11'h000) begin
            failures++;
            $display("FAIL reset_outputs: got byte=%h v=%b e=%b busy=%b, required 00 0 0 0", rx_byte, rx_valid, frame_err, busy);
        end
        checks++;
        if ({rx_byte_s, rx_valid_s, frame_err_s, busy_s} !== 11'h000) begin
            failures++;
            $display("FAIL reset_outputs_slow: got byte=%h v=%b e=%b busy=%b, required 00 0 0 0", rx_byte_s, rx_valid_s, frame_err_s, busy_s);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_9600;
        int t0;
        send(8'h30, 1, -1, 1'b1, t0);
        tick(2);
        checks++;
        if (vq_s.size() != 1 || eq_s.size() != 0) begin
            failures++;
            $display("FAIL rx9600_count: got %0d valid %0d err, required 1 and 0", vq_s.size(), eq_s.size());
        end else begin
            checks++;
            if (vq_s[0].b !== 8'h30) begin
                failures++;
                $display("FAIL rx9600_byte: got %h, required 30", vq_s[0].b);
            end
            checks++;
            if (vq_s[0].t != t0 + 11875) begin
                failures++;
                $display("FAIL rx9600_time: got T0+%0d, required T0+11875", vq_s[0].t - t0);
            end
        end
        vq_s.delete();
        eq_s.delete();
    endtask

    task automatic test_glitch;
        int t0;
        t0 = cyc + 3;
        rx_b = 1'b0;
        tick(100);
        rx_b = 1'b1;
        checks++;
        if (busy_s !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_high: got %b, required 1", busy_s);
        end
        tick(t0 + HS - 1 - cyc);
        checks++;
        if (busy_s !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_before: got %b at T0+%0d, required 1", busy_s, cyc - t0);
        end
        tick();
        checks++;
        if (busy_s !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_after: got %b at T0+%0d, required 0", busy_s, cyc - t0);
        end
        tick(CS);
        checks++;
        if (vq_s.size() + eq_s.size() != 0) begin
            failures++;
            $display("FAIL glitch_no_strobe: got %0d strobes, required 0", vq_s.size() + eq_s.size());
        end
        send(8'h55, 1, -1, 1'b1, t0);
        tick(2);
        checks++;
        if (vq_s.size() != 1 || vq_s[0].b !== 8'h55 || eq_s.size() != 0) begin
            failures++;
            $display("FAIL glitch_next_frame: got %0d valid (first %h), required one 55", vq_s.size(), vq_s.size() ? vq_s[0].b : 8'hxx);
        end
        vq_s.delete();
        eq_s.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] d[2];
        int t[2];
        d[0] = 8'hA5;
        d[1] = 8'h00;
        send(d[0], 1, -1, 1'b0, t[0]);
        send(d[1], 1, -1, 1'b0, t[1]);
        tick(2);
        checks++;
        if (vq.size() != 2 || eq.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: got %0d valid %0d err, required 2 and 0", vq.size(), eq.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (vq[i].b !== d[i] || vq[i].t != t[i] + H + 9 * C) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: got %h at T0+%0d, required %h at T0+%0d", i, vq[i].b, vq[i].t - t[i], d[i], H + 9 * C);
                end
            end
        end
        last_byte = d[1];
        vq.delete();
        eq.delete();
    endtask

    task automatic test_random;
        logic [7:0] d[8];
        int t[8];
        for (int i = 0; i < 8; i++) begin
            d[i] = 8'($urandom_range(1, 255));
            tick($urandom_range(0, 2 * C));
            send(d[i], $urandom_range(1, 2), -1, 1'b0, t[i]);
        end
        tick(2);
        checks++;
        if (vq.size() != 8 || eq.size() != 0) begin
            failures++;
            $display("FAIL random_count: got %0d valid %0d err, required 8 and 0", vq.size(), eq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (vq[i].b !== d[i] || vq[i].t != t[i] + H + 9 * C) begin
                    failures++;
                    $display("FAIL random_frame%0d: got %h at T0+%0d, required %h at T0+%0d", i, vq[i].b, vq[i].t - t[i], d[i], H + 9 * C);
                end
            end
        end
        last_byte = d[7];
        vq.delete();
        eq.delete();
    endtask

    task automatic test_break;
        int t0;
        t0 = cyc + 3;
        rx_a = 1'b0;
        tick(20 * C);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL break_busy_held: got %b, required 1", busy);
        end
        rx_a = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL break_busy_sync: got %b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL break_busy_exit: got %b, required 0", busy);
        end
        checks++;
        if (eq.size() != 1 || vq.size() != 0) begin
            failures++;
            $display("FAIL break_strobes: got %0d err %0d valid, required 1 and 0", eq.size(), vq.size());
        end else begin
            checks++;
            if (eq[0] != t0 + H + 9 * C) begin
                failures++;
                $display("FAIL break_err_time: got T0+%0d, required T0+%0d", eq[0] - t0, H + 9 * C);
            end
        end
        checks++;
        if (rx_byte !== last_byte) begin
            failures++;
            $display("FAIL break_byte_held: got %h, required %h", rx_byte, last_byte);
        end
        vq.delete();
        eq.delete();
        send(8'h7E, 1, -1, 1'b0, t0);
        tick(2);
        checks++;
        if (vq.size() != 1 || vq[0].b !== 8'h7E || eq.size() != 0) begin
            failures++;
            $display("FAIL break_next_frame: got %0d valid (first %h), required one 7e", vq.size(), vq.size() ? vq[0].b : 8'hxx);
        end
        last_byte = 8'h7E;
        vq.delete();
        eq.delete();
    endtask

    task automatic test_enable;
        int t0;
        fork
            send(8'h5A, 1, -1, 1'b0, t0);
            begin
                tick(4 * C);
                en = 1'b0;
                tick();
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL enable_abort_busy: got %b, required 0", busy);
                end
            end
        join
        tick(C);
        en = 1'b1;
        tick(C);
        checks++;
        if (vq.size() + eq.size() != 0 || rx_byte !== last_byte) begin
            failures++;
            $display("FAIL enable_abort: got %0d strobes byte %h, required 0 strobes byte %h", vq.size() + eq.size(), rx_byte, last_byte);
        end
        vq.delete();
        eq.delete();
    endtask

    task automatic test_reset_mid;
        int t0;
        fork
            send(8'hC3, 1, -1, 1'b0, t0);
            begin
                tick(5 * C + H);
                rst_n = 1'b0;
                tick(2);
                checks++;
                if ({rx_byte, rx_valid, frame_err, busy} !== 11'h000) begin
                    failures++;
                    $display("FAIL reset_mid_outputs: got byte=%h v=%b e=%b busy=%b, required 00 0 0 0", rx_byte, rx_valid, frame_err, busy);
                end
            end
        join
        rst_n = 1'b1;
        tick(2 * C);
        checks++;
        if (vq.size() + eq.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_no_strobe: got %0d strobes, required 0", vq.size() + eq.size());
        end
        send(8'h31, 1, -1, 1'b0, t0);
        tick(2);
        checks++;
        if (vq.size() != 1 || vq[0].b !== 8'h31 || eq.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_next: got %0d valid (first %h), required one 31", vq.size(), vq.size() ? vq[0].b : 8'hxx);
        end
        vq.delete();
        eq.delete();
    endtask

    task automatic test_inject;
        int t0;
        logic [7:0] exp_b;
`ifdef UART_RX_MAJORITY_EN
        exp_b = 8'h00;
`else
        exp_b = 8'h04;
`endif
        // invert the line for the one cycle that reaches rx_s exactly at the bit-2 sample point
        send(8'h00, 1, H + 3 * C, 1'b0, t0);
        tick(2);
        checks++;
        if (vq.size() != 1 || vq[0].b !== exp_b || eq.size() != 0) begin
            failures++;
            $display("FAIL inject_bit2: got %0d valid (first %h), required one %h", vq.size(), vq.size() ? vq[0].b : 8'hxx, exp_b);
        end
        vq.delete();
        eq.delete();
    endtask

    initial begin
        test_reset();
        test_9600();
        test_glitch();
        en_s = 1'b0;
        test_back_to_back();
        test_random();
        test_break();
        test_enable();
        test_reset_mid();
        test_inject();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
